// File: rtl/ram_sweep_init.sv
// Single-port synchronous RAM with registered read, read-valid strobe and a
// sequential init sweep that runs after reset release or on a wipe command.
module ram_sweep_init #(
  parameter int n         = 4,
  parameter int m         = 8,
  parameter int INIT_MODE = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ce,
  input  logic         rw,
  input  logic [n-1:0] mar,
  input  logic [m-1:0] dataIn,
  input  logic         wipe,
  output logic [m-1:0] dataOut,
  output logic         rd_valid,
  output logic         busy
);

  localparam int DEPTH = 1 << n;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [n-1:0] ptr_q, ptr_d;
  logic [m-1:0] dout_q, dout_d;
  logic         rdv_q, rdv_d;

  logic [m-1:0] mem_q [DEPTH];
  logic         mem_we;
  logic [n-1:0] mem_waddr;
  logic [m-1:0] mem_wdata;
  logic [m-1:0] sweep_data;

  // Sweep pattern: the pointer zero-extended or truncated to the word width.
  generate
    if (INIT_MODE == 0) begin : g_pat_zero
      assign sweep_data = '0;
    end else if (m <= n) begin : g_pat_trunc
      assign sweep_data = ptr_q[m-1:0];
    end else begin : g_pat_ext
      assign sweep_data = {{(m-n){1'b0}}, ptr_q};
    end
  endgenerate

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      dout_q  <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      rdv_q   <= rdv_d;
    end
  end

  // The array has no reset; the sweep rewrites every word after clr release.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dout_d    = dout_q;
    rdv_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = mar;
    mem_wdata = dataIn;

    unique case (state_q)
      SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = sweep_data;
        ptr_d     = ptr_q + n'(1);
        if (&ptr_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // A wipe wins over any access presented in the same cycle.
        if (wipe) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end else if (ce && rw) begin
          dout_d = mem_q[mar];
          rdv_d  = 1'b1;
        end else if (ce) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_d = SWEEP;
        ptr_d   = '0;
      end
    endcase
  end

  assign dataOut  = dout_q;
  assign rd_valid = rdv_q;
  assign busy     = (state_q == SWEEP);

endmodule

// File: tb/tb_ram_sweep_init.sv
// Bench for ram_sweep_init: directed scenarios plus random traffic against a
// whole-array behavioural model; two extra instances cover other parameter sets.
module tb_ram_sweep_init;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       ce, rw, wipe;
  logic [1:0] mar;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       rd_valid, busy;

  logic       p_ce, p_rw, p_wipe;
  logic [3:0] p_mar;
  logic [7:0] p_din;
  logic [2:0] p1_dout;
  logic       p1_rdv, p1_busy;
  logic [7:0] p0_dout;
  logic       p0_rdv, p0_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_mem [DEPTH];
  int         busy_left;
  logic [7:0] exp_dout;
  logic       exp_rdv;

  ram_sweep_init #(.n(2), .m(8), .INIT_MODE(1)) u_dut (
    .clk(clk), .clr(clr), .ce(ce), .rw(rw), .mar(mar), .dataIn(dataIn),
    .wipe(wipe), .dataOut(dataOut), .rd_valid(rd_valid), .busy(busy)
  );

  ram_sweep_init #(.n(4), .m(3), .INIT_MODE(1)) u_p1 (
    .clk(clk), .clr(clr), .ce(p_ce), .rw(p_rw), .mar(p_mar), .dataIn(p_din[2:0]),
    .wipe(p_wipe), .dataOut(p1_dout), .rd_valid(p1_rdv), .busy(p1_busy)
  );

  ram_sweep_init #(.n(4), .m(8), .INIT_MODE(0)) u_p0 (
    .clk(clk), .clr(clr), .ce(p_ce), .rw(p_rw), .mar(p_mar), .dataIn(p_din),
    .wipe(p_wipe), .dataOut(p0_dout), .rd_valid(p0_rdv), .busy(p0_busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k % 256);
  endfunction

  // After reset or an accepted wipe the whole array is known to become the
  // pattern; reads are blocked until then, so the model applies it at once.
  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = pat(k);
    busy_left = DEPTH;
    exp_dout  = 8'h00;
    exp_rdv   = 1'b0;
  endtask

  task automatic model_edge(input logic c, input logic r, input logic [1:0] a,
                            input logic [7:0] d, input logic w);
    exp_rdv = 1'b0;
    if (busy_left > 0) begin
      busy_left--;
    end else if (w) begin
      for (int k = 0; k < DEPTH; k++) exp_mem[k] = pat(k);
      busy_left = DEPTH;
    end else if (c && r) begin
      exp_dout = exp_mem[a];
      exp_rdv  = 1'b1;
    end else if (c) begin
      exp_mem[a] = d;
    end
  endtask

  task automatic step(input logic c, input logic r, input logic [1:0] a,
                      input logic [7:0] d, input logic w);
    ce = c; rw = r; mar = a; dataIn = d; wipe = w;
    @(posedge clk);
    model_edge(c, r, a, d, w);
    #1;
    check_eq("busy", busy, busy_left > 0);
    check_eq("rd_valid", rd_valid, exp_rdv);
    check_eq("dataOut", dataOut, exp_dout);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    #1;
    check_eq("rst_dataOut", dataOut, 8'h00);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b1);
    model_reset();
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic count_busy(input string tag, input int exp_len);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      cnt++;
    end
    check_eq(tag, cnt, exp_len);
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, 1'b1, 2'(k), 8'h00, 1'b0);
      check_eq(tag, dataOut, k);
      check_eq({tag, "_vld"}, rd_valid, 1'b1);
    end
  endtask

  initial begin
    logic       rc, rr, rw_w;
    logic [1:0] ra;
    logic [7:0] rd;
    int         cnt;

    clr = 1'b0; ce = 1'b0; rw = 1'b0; mar = '0; dataIn = '0; wipe = 1'b0;
    p_ce = 1'b0; p_rw = 1'b0; p_mar = '0; p_din = '0; p_wipe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_dataOut", dataOut, 8'h00);
    check_eq("init_rd_valid", rd_valid, 1'b0);
    check_eq("init_busy", busy, 1'b1);
    model_reset();
    @(negedge clk);
    clr = 1'b1;

    // Reset sweep then read back the pattern
    count_busy("t1_busy_len", 4);
    read_all("t1_rd");
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    check_eq("t1_vld_drop", rd_valid, 1'b0);

    // Write then read on the next edge
    step(1'b1, 1'b0, 2'd2, 8'hA5, 1'b0);
    check_eq("t2_wr_vld", rd_valid, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h00, 1'b0);
    check_eq("t2_rd_a5", dataOut, 8'hA5);
    check_eq("t2_rd_vld", rd_valid, 1'b1);
    step(1'b1, 1'b1, 2'd1, 8'h00, 1'b0);
    check_eq("t2_rd_01", dataOut, 8'h01);

    // Wipe colliding with a write, and reads locked out while busy
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 2'(k), 8'hFF, 1'b0);
    step(1'b1, 1'b0, 2'd3, 8'h77, 1'b1);
    check_eq("t3_busy", busy, 1'b1);
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b0);
    check_eq("t3_lock_vld", rd_valid, 1'b0);
    check_eq("t3_lock_hold", dataOut, 8'h01);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    count_busy("t3_busy_rest", 2);
    read_all("t3_rd");

    // ce gating
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd1, 8'h3C, 1'b0);
      check_eq("t4_vld", rd_valid, 1'b0);
      check_eq("t4_hold", dataOut, 8'h03);
    end
    step(1'b1, 1'b1, 2'd1, 8'h00, 1'b0);
    check_eq("t4_rd", dataOut, 8'h01);

    // Reset in the middle of a sweep
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    do_reset();
    count_busy("t5_busy_len", 4);
    read_all("t5_rd");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rc   = 1'($urandom_range(0, 3) != 0);
      rr   = 1'($urandom_range(0, 1));
      ra   = 2'($urandom_range(0, 3));
      rd   = 8'($urandom);
      rw_w = 1'($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      else step(rc, rr, ra, rd, rw_w);
    end

    // Other parameter sets
    do_reset();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!p1_busy) break;
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      check_eq("t6_p0_busy", p0_busy, p1_busy);
      cnt++;
    end
    check_eq("t6_busy_len", cnt, 16);
    for (int k = 0; k < 16; k++) begin
      p_ce = 1'b1; p_rw = 1'b1; p_mar = 4'(k);
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      check_eq("t6_p1_rd", p1_dout, k % 8);
      check_eq("t6_p1_vld", p1_rdv, 1'b1);
      check_eq("t6_p0_rd", p0_dout, 8'h00);
      check_eq("t6_p0_vld", p0_rdv, 1'b1);
      if (k == 13) check_eq("t6_word13", p1_dout, 3'b101);
    end
    p_ce = 1'b0;
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    check_eq("t6_p1_vld_drop", p1_rdv, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
